mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares the single DPI-backed physical memory port (pmem_read/pmem_write) between the instruction-fetch requester and the load/store requester of the RV64 core. Allows one outstanding transaction at a time. Arbitration is fixed-priority LSU-over-IFU with a starvation bound for IFU. The block sits between the core (fetch and memory stage) and the memory wrapper that calls the DPI functions.

## Interface
- STARVE_MAX, 4: number of consecutive LSU grants, made while IFU is waiting, after which IFU wins the next contended grant (range 1..15).
- clk  input  1  core clock; all state updates on posedge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- if_req_valid  input  1  fetch request.
- if_req_ready  output  1  fetch request accepted this cycle.
- if_req_addr  input  64  fetch address (8-byte aligned).
- if_rsp_valid  output  1  fetch data valid, one-cycle pulse.
- if_rsp_data  output  64  fetch data.
- ls_req_valid  input  1  load/store request.
- ls_req_ready  output  1  load/store request accepted this cycle.
- ls_req_addr  input  64  data address.
- ls_req_we  input  1  1 = store, 0 = load.
- ls_req_wdata  input  64  store data.
- ls_req_wmask  input  8  store byte mask.
- ls_rsp_valid  output  1  load data or store acknowledge, one-cycle pulse.
- ls_rsp_data  output  64  load data (mem_rsp_data is passed through for stores).
- mem_req_valid  output  1  request to the memory wrapper.
- mem_req_ready  input  1  memory accepts the request.
- mem_req_addr  output  64  address.
- mem_req_we  output  1  write enable.
- mem_req_wdata  output  64  write data.
- mem_req_wmask  output  8  write mask; 8'h00 for reads.
- mem_rsp_valid  input  1  memory response.
- mem_rsp_data  input  64  memory read data.
- busy  output  1  state != IDLE.
- err  output  1  sticky: mem_rsp_valid arrived outside WAIT.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE.** The winner is selected combinationally:
  - LSU only valid: LSU wins.
  - IFU only valid: IFU wins.
  - Both valid: LSU wins, unless starve_cnt == STARVE_MAX, in which case IFU wins.
  - The winner's req_ready = 1 and the loser's req_ready = 0. Ready is only ever high in IDLE.
- **Accept (valid & ready).** Latch owner, addr, we, wdata, and wmask into registers. A fetch latches we = 0 and wmask = 0. Go to ISSUE.
- **Starvation counter starve_cnt** (4 bits, updated on accept):
  - LSU accepted while if_req_valid = 1: saturating increment.
  - IFU accepted, or LSU accepted while if_req_valid = 0: clear to 0.
- **ISSUE.** mem_req_valid = 1, driven from the latched registers. Hold until mem_req_ready = 1, then go to WAIT. The request fields do not change while mem_req_valid = 1.
- **WAIT.** On mem_rsp_valid, register mem_rsp_data into the owner's rsp_data and go to RESP.
- **RESP.** The owner's rsp_valid = 1 for exactly one cycle, then go to IDLE. The non-owner's rsp_valid stays 0.
- **rsp_data.** Holds its last value until the next response. Reset value is 0.
- **err.** mem_rsp_valid in IDLE, ISSUE, or RESP sets err. The stray response is otherwise ignored: no state change, no rsp pulse. Only reset clears err.
- **Reset mid-transaction.** Asserting rst asynchronously forces IDLE and drops the in-flight transaction; no response is delivered. A late mem_rsp_valid after reset sets err.

## Timing
- Reset values: all outputs 0; state = IDLE; starve_cnt = 0; all latched registers = 0.
- Accept at edge T, then mem_req_valid is high in cycle T+1.
- With mem_req_ready = 1 in cycle T+1, the state is WAIT from T+2.
- mem_rsp_valid in cycle X, then rsp_valid is high in cycle X+1.
- The next accept is possible at the edge ending cycle X+2, so requester ready can go high in cycle X+2.
- Minimum turnaround with zero memory latency (mem_rsp_valid in the first WAIT cycle): 4 cycles per transaction.
- A response arriving in the same cycle that mem_req_ready completes the handshake (ISSUE state) counts as stray and sets err. The memory must respond no earlier than the cycle after acceptance.
- No combinational path from mem_rsp_* to requester outputs. req_ready depends combinationally on state, both req_valid, and starve_cnt.

## Test plan
- Reset, then IFU read 0x8000_0000 with memory returning 0x0000_0013_0010_0073 one cycle after accept → mem_req_valid high in cycle T+1 with wmask 0x00; if_rsp_valid pulses once with that data; ls_rsp_valid stays 0; busy falls afterwards.
- LSU store of addr 0x8000_1000, wdata 0x1234_5678_8765_4321, wmask 0x03, with mem_req_ready held low 3 cycles → mem_req fields stay stable through the stall; exactly one ls_rsp_valid pulse.
- Both requesters continuously valid with STARVE_MAX = 4 → grant sequence LSU, LSU, LSU, LSU, IFU, then repeats; starve_cnt returns to 0 after each IFU grant.
- mem_rsp_valid pulsed while in IDLE, then a normal IFU read → err = 1 and stays 1; the IFU read still completes correctly; no spurious rsp pulses.
- rst driven low mid-WAIT during an LSU load, released, then the old response arrives → all outputs 0 during reset; after release, err = 1 and no ls_rsp_valid; a following IFU read completes normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single physical memory port between instruction fetch and
// load/store. LSU has fixed priority, IFU has a starvation bound, one transaction in flight.
module mem_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req_valid,
  output logic        if_req_ready,
  input  logic [63:0] if_req_addr,
  output logic        if_rsp_valid,
  output logic [63:0] if_rsp_data,
  input  logic        ls_req_valid,
  output logic        ls_req_ready,
  input  logic [63:0] ls_req_addr,
  input  logic        ls_req_we,
  input  logic [63:0] ls_req_wdata,
  input  logic [7:0]  ls_req_wmask,
  output logic        ls_rsp_valid,
  output logic [63:0] ls_rsp_data,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [63:0] mem_req_addr,
  output logic        mem_req_we,
  output logic [63:0] mem_req_wdata,
  output logic [7:0]  mem_req_wmask,
  input  logic        mem_rsp_valid,
  input  logic [63:0] mem_rsp_data,
  output logic        busy,
  output logic        err
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t     state;
  logic       owner_ls;
  logic [3:0] starve_cnt;
  logic       ls_win;
  logic       if_win;
  logic       ls_acc;
  logic       if_acc;

  // IFU only beats a contending LSU once the LSU has won STARVE_MAX times in a row
  always_comb begin
    ls_win = ls_req_valid && (!if_req_valid || (starve_cnt != STARVE_LIM));
    if_win = if_req_valid && !ls_win;
  end

  assign ls_req_ready = rst && (state == IDLE) && ls_win;
  assign if_req_ready = rst && (state == IDLE) && if_win;
  assign ls_acc       = ls_req_valid && ls_req_ready;
  assign if_acc       = if_req_valid && if_req_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      owner_ls      <= 1'b0;
      starve_cnt    <= 4'd0;
      mem_req_valid <= 1'b0;
      mem_req_addr  <= 64'd0;
      mem_req_we    <= 1'b0;
      mem_req_wdata <= 64'd0;
      mem_req_wmask <= 8'h00;
      if_rsp_valid  <= 1'b0;
      if_rsp_data   <= 64'd0;
      ls_rsp_valid  <= 1'b0;
      ls_rsp_data   <= 64'd0;
      busy          <= 1'b0;
      err           <= 1'b0;
    end else begin
      if (mem_rsp_valid && (state != WAIT)) begin
        err <= 1'b1;
      end
      if_rsp_valid <= 1'b0;
      ls_rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (ls_acc || if_acc) begin
            owner_ls      <= ls_acc;
            mem_req_addr  <= ls_acc ? ls_req_addr : if_req_addr;
            mem_req_we    <= ls_acc && ls_req_we;
            mem_req_wdata <= ls_acc ? ls_req_wdata : 64'd0;
            mem_req_wmask <= (ls_acc && ls_req_we) ? ls_req_wmask : 8'h00;
            if (ls_acc && if_req_valid) begin
              starve_cnt <= (starve_cnt == 4'hF) ? 4'hF : starve_cnt + 4'd1;
            end else begin
              starve_cnt <= 4'd0;
            end
            mem_req_valid <= 1'b1;
            busy          <= 1'b1;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= WAIT;
          end
        end
        WAIT: begin
          if (mem_rsp_valid) begin
            if (owner_ls) begin
              ls_rsp_data  <= mem_rsp_data;
              ls_rsp_valid <= 1'b1;
            end else begin
              if_rsp_data  <= mem_rsp_data;
              if_rsp_valid <= 1'b1;
            end
            state <= RESP;
          end
        end
        RESP: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized traffic, checked every cycle
// against a transaction-level model of the arbiter.
module tb_mem_arbiter;

  localparam int STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_valid, if_req_ready, if_rsp_valid;
  logic [63:0] if_req_addr, if_rsp_data;
  logic        ls_req_valid, ls_req_ready, ls_req_we, ls_rsp_valid;
  logic [63:0] ls_req_addr, ls_req_wdata, ls_rsp_data;
  logic [7:0]  ls_req_wmask;
  logic        mem_req_valid, mem_req_ready, mem_req_we, mem_rsp_valid;
  logic [63:0] mem_req_addr, mem_req_wdata, mem_rsp_data;
  logic [7:0]  mem_req_wmask;
  logic        busy, err;

  mem_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
    .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
    .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_req_addr(ls_req_addr),
    .ls_req_we(ls_req_we), .ls_req_wdata(ls_req_wdata), .ls_req_wmask(ls_req_wmask),
    .ls_rsp_valid(ls_rsp_valid), .ls_rsp_data(ls_rsp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_we(mem_req_we), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Handshakes seen at the last clock edge, used by the stimulus to renew requests
  logic if_acc_q = 1'b0, ls_acc_q = 1'b0, mem_hs_q = 1'b0;
  always @(posedge clk) begin
    if_acc_q <= if_req_valid && if_req_ready;
    ls_acc_q <= ls_req_valid && ls_req_ready;
    mem_hs_q <= mem_req_valid && mem_req_ready;
  end

  // Transaction-level reference: one transaction record and its lifecycle milestones
  bit          m_active, m_taken, m_has_data, m_owner_ls, m_we, m_err;
  logic [63:0] m_addr, m_wdata, m_if_data, m_ls_data;
  logic [7:0]  m_wmask;
  int          m_starve;

  function automatic void model_clear();
    m_active = 0; m_taken = 0; m_has_data = 0; m_owner_ls = 0; m_we = 0; m_err = 0;
    m_addr = '0; m_wdata = '0; m_if_data = '0; m_ls_data = '0; m_wmask = '0; m_starve = 0;
  endfunction

  always @(negedge clk) begin : compare
    bit exp_ls, exp_if, exp_mreq, in_wait;
    if (!rst) begin
      check_bit("rst_if_ready", if_req_ready, 1'b0);
      check_bit("rst_ls_ready", ls_req_ready, 1'b0);
      check_bit("rst_if_rsp_valid", if_rsp_valid, 1'b0);
      check_bit("rst_ls_rsp_valid", ls_rsp_valid, 1'b0);
      check_val("rst_if_rsp_data", if_rsp_data, 64'd0);
      check_val("rst_ls_rsp_data", ls_rsp_data, 64'd0);
      check_bit("rst_mem_req_valid", mem_req_valid, 1'b0);
      check_val("rst_mem_req_addr", mem_req_addr, 64'd0);
      check_val("rst_mem_req_wmask", 64'(mem_req_wmask), 64'd0);
      check_bit("rst_busy", busy, 1'b0);
      check_bit("rst_err", err, 1'b0);
      model_clear();
    end else begin
      exp_ls   = !m_active && ls_req_valid && (!if_req_valid || m_starve < STARVE_MAX);
      exp_if   = !m_active && if_req_valid && !exp_ls;
      exp_mreq = m_active && !m_taken;
      in_wait  = m_active && m_taken && !m_has_data;
      check_bit("if_req_ready", if_req_ready, exp_if);
      check_bit("ls_req_ready", ls_req_ready, exp_ls);
      check_bit("busy", busy, m_active);
      check_bit("mem_req_valid", mem_req_valid, exp_mreq);
      if (exp_mreq) begin
        check_val("mem_req_addr", mem_req_addr, m_addr);
        check_bit("mem_req_we", mem_req_we, m_we);
        check_val("mem_req_wmask", 64'(mem_req_wmask), 64'(m_we ? m_wmask : 8'h00));
        if (m_we) check_val("mem_req_wdata", mem_req_wdata, m_wdata);
      end
      check_bit("if_rsp_valid", if_rsp_valid, m_active && m_has_data && !m_owner_ls);
      check_bit("ls_rsp_valid", ls_rsp_valid, m_active && m_has_data && m_owner_ls);
      check_val("if_rsp_data", if_rsp_data, m_if_data);
      check_val("ls_rsp_data", ls_rsp_data, m_ls_data);
      check_bit("err", err, m_err);
      // what the coming clock edge does to the transaction
      if (mem_rsp_valid && !in_wait) m_err = 1;
      if (m_active) begin
        if (m_has_data) begin
          m_active = 0; m_taken = 0; m_has_data = 0;
        end else if (m_taken) begin
          if (mem_rsp_valid) begin
            m_has_data = 1;
            if (m_owner_ls) m_ls_data = mem_rsp_data;
            else m_if_data = mem_rsp_data;
          end
        end else if (mem_req_ready) begin
          m_taken = 1;
        end
      end else if (exp_ls || exp_if) begin
        m_active   = 1;
        m_owner_ls = exp_ls;
        m_addr     = exp_ls ? ls_req_addr : if_req_addr;
        m_we       = exp_ls && ls_req_we;
        m_wdata    = ls_req_wdata;
        m_wmask    = ls_req_wmask;
        if (exp_ls && if_req_valid) m_starve = (m_starve < 15) ? m_starve + 1 : 15;
        else m_starve = 0;
      end
    end
  end

  bit mem_pend = 0;
  int mem_lat = 0;
  bit stray_en = 0;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Randomized memory wrapper: responds 0..3 cycles into WAIT, occasional stray pulses
  task automatic mem_service();
    mem_rsp_valid = 1'b0;
    if (mem_hs_q) begin
      mem_pend = 1;
      mem_lat  = int'($urandom_range(0, 3));
    end
    if (mem_pend) begin
      if (mem_lat == 0) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = {$urandom, $urandom};
        mem_pend      = 0;
      end else begin
        mem_lat--;
      end
    end else if (stray_en && $urandom_range(0, 299) == 0) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = {$urandom, $urandom};
    end
    mem_req_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic apply_stimulus();
    if (if_acc_q || !if_req_valid) begin
      if_req_valid = ($urandom_range(0, 99) < 70);
      if_req_addr  = {$urandom, $urandom} & ~64'h7;
    end
    if (ls_acc_q || !ls_req_valid) begin
      ls_req_valid = ($urandom_range(0, 99) < 70);
      ls_req_addr  = {$urandom, $urandom};
      ls_req_we    = 1'($urandom_range(0, 1));
      ls_req_wdata = {$urandom, $urandom};
      ls_req_wmask = 8'($urandom);
    end
  endtask

  task automatic drain(input string tag);
    int budget = 60;
    if_req_valid = 1'b0;
    ls_req_valid = 1'b0;
    stray_en     = 0;
    while (busy && budget > 0) begin
      step();
      mem_service();
      budget--;
    end
    check_bit({tag, "_drained"}, busy, 1'b0);
    step();
    mem_rsp_valid = 1'b0;
    mem_req_ready = 1'b0;
    mem_pend      = 0;
  endtask

  // Single fetch with a first-WAIT-cycle memory response and literal checks each cycle
  task automatic ifu_read(input string tag, input logic [63:0] addr, input logic [63:0] data);
    step();
    if_req_valid = 1'b1;
    if_req_addr  = addr;
    #1 check_bit({tag, "_if_ready"}, if_req_ready, 1'b1);
    step();
    if_req_valid  = 1'b0;
    mem_req_ready = 1'b1;
    #1;
    check_bit({tag, "_mreq_valid"}, mem_req_valid, 1'b1);
    check_val({tag, "_mreq_addr"}, mem_req_addr, addr);
    check_val({tag, "_mreq_wmask"}, 64'(mem_req_wmask), 64'h0);
    check_bit({tag, "_mreq_we"}, mem_req_we, 1'b0);
    step();
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = data;
    #1 check_bit({tag, "_mreq_dropped"}, mem_req_valid, 1'b0);
    step();
    mem_rsp_valid = 1'b0;
    #1;
    check_bit({tag, "_if_rsp_pulse"}, if_rsp_valid, 1'b1);
    check_val({tag, "_if_rsp_data"}, if_rsp_data, data);
    check_bit({tag, "_ls_rsp_quiet"}, ls_rsp_valid, 1'b0);
    step();
    #1;
    check_bit({tag, "_if_rsp_end"}, if_rsp_valid, 1'b0);
    check_bit({tag, "_busy_low"}, busy, 1'b0);
    check_val({tag, "_if_data_held"}, if_rsp_data, data);
  endtask

  logic exp_seq [10];

  initial begin
    int g, cyc;
    exp_seq = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    rst = 1'b0;
    if_req_valid = 1'b0; if_req_addr = '0;
    ls_req_valid = 1'b0; ls_req_addr = '0; ls_req_we = 1'b0; ls_req_wdata = '0; ls_req_wmask = '0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;

    ifu_read("t1", 64'h8000_0000, 64'h0000_0013_0010_0073);

    // LSU store with a three-cycle memory stall
    step();
    ls_req_valid = 1'b1; ls_req_addr = 64'h8000_1000; ls_req_we = 1'b1;
    ls_req_wdata = 64'h1234_5678_8765_4321; ls_req_wmask = 8'h03;
    step();
    ls_req_valid = 1'b0; ls_req_we = 1'b0; ls_req_wdata = '0; ls_req_wmask = '0;
    mem_req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) mem_req_ready = 1'b1;
      #1;
      check_bit("t2_mreq_valid", mem_req_valid, 1'b1);
      check_val("t2_mreq_addr", mem_req_addr, 64'h8000_1000);
      check_val("t2_mreq_wdata", mem_req_wdata, 64'h1234_5678_8765_4321);
      check_val("t2_mreq_wmask", 64'(mem_req_wmask), 64'h03);
      check_bit("t2_mreq_we", mem_req_we, 1'b1);
      step();
    end
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 64'h0000_0000_0000_00AA;
    step();
    mem_rsp_valid = 1'b0;
    #1;
    check_bit("t2_ls_rsp_pulse", ls_rsp_valid, 1'b1);
    check_val("t2_ls_rsp_data", ls_rsp_data, 64'hAA);
    check_bit("t2_if_rsp_quiet", if_rsp_valid, 1'b0);
    step();
    #1 check_bit("t2_ls_rsp_end", ls_rsp_valid, 1'b0);

    // Both requesters always valid: four LSU grants then one IFU grant, repeating
    if_req_valid = 1'b1; if_req_addr = 64'h8000_0100;
    ls_req_valid = 1'b1; ls_req_addr = 64'h8000_3000; ls_req_we = 1'b0;
    g = 0; cyc = 0;
    while (g < 10 && cyc < 300) begin
      step();
      cyc++;
      mem_service();
      if (ls_acc_q || if_acc_q) begin
        check_bit($sformatf("t3_grant%0d_is_lsu", g), ls_acc_q, exp_seq[g]);
        g++;
      end
    end
    check_val("t3_grant_count", 64'(g), 64'd10);
    drain("t3");

    // Randomized traffic
    stray_en = 1;
    for (int c = 0; c < 1500; c++) begin
      step();
      mem_service();
      apply_stimulus();
    end
    drain("rnd");

    // Stray response in IDLE makes err sticky without disturbing a later fetch
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    #1 check_bit("t4_err_clear", err, 1'b0);
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 64'hDEAD_BEEF_0000_0001;
    step();
    mem_rsp_valid = 1'b0;
    #1;
    check_bit("t4_err_set", err, 1'b1);
    check_bit("t4_no_if_rsp", if_rsp_valid, 1'b0);
    check_bit("t4_no_ls_rsp", ls_rsp_valid, 1'b0);
    check_bit("t4_busy_idle", busy, 1'b0);
    ifu_read("t4", 64'h8000_0008, 64'h0000_0000_1111_2222);
    check_bit("t4_err_sticky", err, 1'b1);

    // Reset while an LSU load waits for memory; the late response must be dropped
    step();
    ls_req_valid = 1'b1; ls_req_we = 1'b0; ls_req_addr = 64'h8000_2000;
    step();
    ls_req_valid  = 1'b0;
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    #1 check_bit("t5_busy_wait", busy, 1'b1);
    step();
    rst = 1'b0;
    if_req_valid = 1'b1;
    ls_req_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      check_bit("t5_rst_busy", busy, 1'b0);
      check_bit("t5_rst_err", err, 1'b0);
      check_bit("t5_rst_if_ready", if_req_ready, 1'b0);
      check_bit("t5_rst_ls_ready", ls_req_ready, 1'b0);
      check_val("t5_rst_ls_data", ls_rsp_data, 64'd0);
      step();
    end
    rst = 1'b1;
    if_req_valid = 1'b0;
    ls_req_valid = 1'b0;
    step();
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 64'h0BAD_0BAD_0BAD_0BAD;
    step();
    mem_rsp_valid = 1'b0;
    #1;
    check_bit("t5_late_err", err, 1'b1);
    check_bit("t5_no_ls_rsp", ls_rsp_valid, 1'b0);
    check_bit("t5_busy_idle", busy, 1'b0);
    step();
    #1 check_bit("t5_no_ls_rsp2", ls_rsp_valid, 1'b0);
    ifu_read("t5", 64'h8000_0010, 64'h0000_0000_3333_4444);

    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] simulation did not complete");
  end

endmodule
